multi_player_hold_fsm: RTL
==========================

Name: multi_player_hold_fsm

Overview:
- Per-player held-item/action state machine for NUM_PLAYERS cooks, driven by a single system clock and qualified by a once-per-frame tick.
- Detects carry presses on the rising edge and times chopping with a per-player frame counter.
- Issues grid write-back requests (pickup clears the cell, drop/transform writes it) through one shared valid/ready port with round-robin arbitration.
- Sits between the input/movement logic and the object-grid store.

Parameters:
- NUM_PLAYERS, 2, number of independent player slots (1..4).
- CHOP_FRAMES, 60, frames chop must be held on a whole onion to produce a chopped onion.
- CW, $clog2(CHOP_FRAMES+1), chop counter width (derived).

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame; all player transitions evaluate only when high
- chop  in  NUM_PLAYERS  per-player chop/action button level
- carry  in  NUM_PLAYERS  per-player carry button level
- obj_front  in  NUM_PLAYERS x 4  grid object code in the cell each player faces
- front_x  in  NUM_PLAYERS x 4  column of faced cell
- front_y  in  NUM_PLAYERS x 3  row of faced cell
- player_state  out  NUM_PLAYERS x 4  per-player state code (P_* encoding)
- chop_progress  out  NUM_PLAYERS x CW  per-player chop counter for progress-bar rendering
- wr_valid  out  1  grid write request pending
- wr_ready  in  1  grid store accepts the write this cycle
- wr_x  out  4  target column
- wr_y  out  3  target row
- wr_code  out  4  new G_* code for target cell
- wr_player  out  $clog2(NUM_PLAYERS)  requesting player index

Behaviour:
- Reset (synchronous): all player_state = P_NOTHING, chop_progress = 0, pending slots cleared, wr_valid = 0 the following cycle, RR pointer = 0, edge-detect registers = 0. Reset mid-request drops the request; no write is issued.
- Edge detection: carry_rise = carry & ~carry_q; chop_rise likewise. The _q registers update only on frame_tick.
- Stall: a player with a pending write ignores all inputs until the write is accepted; its state and counter hold.
- Transitions (on frame_tick, player not stalled):
  - NOTHING + carry_rise + obj_front in {ONION_WHOLE, ONION_CHOPPED, BOWL_EMPTY, BOWL_FULL, POT_EMPTY, POT_RAW, POT_COOKED, EXTINGUISHER} -> matching P_* state; write G_EMPTY to front cell. P_EXT_OFF corresponds to EXTINGUISHER.
  - Holding any item + carry_rise + obj_front == G_EMPTY -> NOTHING; write the held item's G_* code. P_EXT_ON drops as G_EXTINGUISHER.
  - NOTHING + chop + obj_front == ONION_WHOLE -> CHOPPING, counter = 1.
  - CHOPPING + chop: counter++. When counter reaches CHOP_FRAMES: write G_ONION_CHOPPED, state -> NOTHING, counter -> 0.
  - CHOPPING + ~chop, or obj_front != ONION_WHOLE -> NOTHING, counter -> 0, no write.
  - POT_EMPTY + chop_rise + front ONION_CHOPPED -> POT_RAW; write G_EMPTY.
  - BOWL_EMPTY + chop_rise + front POT_COOKED -> BOWL_FULL; write G_POT_EMPTY.
  - POT_COOKED + chop_rise + front BOWL_EMPTY -> POT_EMPTY; write G_BOWL_FULL.
  - EXT_OFF + chop -> EXT_ON. EXT_ON + ~chop -> EXT_OFF.
  - EXT_ON + front G_FIRE or G_POT_FIRE -> write G_EMPTY or G_POT_EMPTY respectively; state stays EXT_ON.
  - All other combinations: hold state.
- Cell conflicts:
  - A transition requiring a write is suppressed if its (front_x, front_y) matches any pending slot.
  - If two players target the same cell on the same tick, the lowest index wins; the others hold.
- Arbiter:
  - wr_valid = OR of pending slots.
  - Selects the first pending slot at or after the RR pointer; wr_* outputs are combinational from that slot.
  - On wr_valid & wr_ready: clear the slot, pointer = granted + 1 (mod NUM_PLAYERS).
  - A new request and a grant in the same cycle for different players are both honoured.
- Latency: state and pending slot update in the frame_tick cycle; wr_valid is high on the next cycle.

Decomposition:
- overcooked_pkg holds the P_* and G_* codes (4-bit), direction codes, and a held_to_grid mapping function.
- Sub-module player_action_slot, instantiated NUM_PLAYERS times, contains the per-player FSM, edge detect, chop counter and pending slot.
- The top level contains the conflict resolution and the round-robin arbiter.

Test Plan:
- P0: carry rises facing ONION_WHOLE at (3,2) -> state 2; write (3,2,G_EMPTY) once ready=1. Carry held on later ticks -> no further transition.
- P0 chop held on ONION_WHOLE, CHOP_FRAMES=4 -> progress 1,2,3, then write G_ONION_CHOPPED on tick 4, state 0. Release at tick 2 -> state 0, progress 0, no write.
- P0 and P1 both carry_rise on ONION_WHOLE at (5,1) same tick -> only P0 becomes state 2; P1 stays 0.
- wr_ready held low 10 cycles with P0 and P1 requests pending -> P0 frozen despite inputs. Ready high -> grants P0 then P1, pointer ends at 0.
- P0 EXT_OFF, chop held facing G_POT_FIRE -> EXT_ON; write G_POT_EMPTY; release -> EXT_OFF.
- Reset asserted while wr_valid=1, ready=0 -> next cycle wr_valid=0, all states 0, progress 0.

Source files
------------

// File: rtl/multi_player_hold_fsm_pkg.sv
// Shared codes for the cook hold/action controller: player states, grid
// object codes, facing directions and the mappings between held items and
// grid cells.
package multi_player_hold_fsm_pkg;

   typedef enum logic [3:0] {
      P_NOTHING       = 4'd0,
      P_CHOPPING      = 4'd1,
      P_ONION_WHOLE   = 4'd2,
      P_ONION_CHOPPED = 4'd3,
      P_BOWL_EMPTY    = 4'd4,
      P_BOWL_FULL     = 4'd5,
      P_POT_EMPTY     = 4'd6,
      P_POT_RAW       = 4'd7,
      P_POT_COOKED    = 4'd8,
      P_EXT_OFF       = 4'd9,
      P_EXT_ON        = 4'd10
   } pstate_t;

   typedef enum logic [3:0] {
      G_EMPTY         = 4'd0,
      G_ONION_WHOLE   = 4'd1,
      G_ONION_CHOPPED = 4'd2,
      G_BOWL_EMPTY    = 4'd3,
      G_BOWL_FULL     = 4'd4,
      G_POT_EMPTY     = 4'd5,
      G_POT_RAW       = 4'd6,
      G_POT_COOKED    = 4'd7,
      G_EXTINGUISHER  = 4'd8,
      G_FIRE          = 4'd9,
      G_POT_FIRE      = 4'd10,
      G_COUNTER       = 4'd11
   } gcode_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   // Grid code written back when a held item is put down.
   function automatic logic [3:0] held_to_grid(input pstate_t s);
      case (s)
         P_ONION_WHOLE:   return G_ONION_WHOLE;
         P_ONION_CHOPPED: return G_ONION_CHOPPED;
         P_BOWL_EMPTY:    return G_BOWL_EMPTY;
         P_BOWL_FULL:     return G_BOWL_FULL;
         P_POT_EMPTY:     return G_POT_EMPTY;
         P_POT_RAW:       return G_POT_RAW;
         P_POT_COOKED:    return G_POT_COOKED;
         P_EXT_OFF:       return G_EXTINGUISHER;
         P_EXT_ON:        return G_EXTINGUISHER;
         default:         return G_EMPTY;
      endcase
   endfunction

   // Player state after picking up a grid object; P_NOTHING if not portable.
   function automatic pstate_t grid_to_held(input logic [3:0] g);
      case (g)
         G_ONION_WHOLE:   return P_ONION_WHOLE;
         G_ONION_CHOPPED: return P_ONION_CHOPPED;
         G_BOWL_EMPTY:    return P_BOWL_EMPTY;
         G_BOWL_FULL:     return P_BOWL_FULL;
         G_POT_EMPTY:     return P_POT_EMPTY;
         G_POT_RAW:       return P_POT_RAW;
         G_POT_COOKED:    return P_POT_COOKED;
         G_EXTINGUISHER:  return P_EXT_OFF;
         default:         return P_NOTHING;
      endcase
   endfunction

   function automatic logic is_pickup(input logic [3:0] g);
      return grid_to_held(g) != P_NOTHING;
   endfunction

   function automatic logic is_holding(input pstate_t s);
      return (s >= P_ONION_WHOLE) && (s <= P_EXT_ON);
   endfunction

endpackage

// File: rtl/multi_player_hold_fsm_if.sv
// Grid write-back port: one request at a time, accepted on valid & ready.
interface multi_player_hold_fsm_if #(
   parameter int PW = 1
);
   logic          wr_valid;
   logic          wr_ready;
   logic [3:0]    wr_x;
   logic [2:0]    wr_y;
   logic [3:0]    wr_code;
   logic [PW-1:0] wr_player;

   modport master (
      output wr_valid, wr_x, wr_y, wr_code, wr_player,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_x, wr_y, wr_code, wr_player,
      output wr_ready
   );
endinterface

// File: rtl/multi_player_hold_fsm_player_action_slot.sv
// One cook: held-item FSM, frame-qualified edge detect, chop timer and a
// single pending grid-write slot. While the slot is pending the player is
// frozen.
//
//   state           | meaning
//   ----------------+--------------------------------------------
//   P_NOTHING       | empty-handed
//   P_CHOPPING      | chopping a whole onion, cnt = frames so far
//   P_ONION_WHOLE.. | carrying the matching item
//   P_POT_COOKED    |
//   P_EXT_OFF       | carrying extinguisher, not spraying
//   P_EXT_ON        | carrying extinguisher, spraying
module player_action_slot
   import multi_player_hold_fsm_pkg::*;
#(
   parameter int CHOP_FRAMES = 60,
   parameter int CW          = $clog2(CHOP_FRAMES + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          frame_tick,
   input  logic          chop,
   input  logic          carry,
   input  logic [3:0]    obj_front,
   input  logic [3:0]    front_x,
   input  logic [2:0]    front_y,
   input  logic          blocked,
   input  logic          grant,
   output logic [3:0]    state_code,
   output logic [CW-1:0] progress,
   output logic          req,
   output logic          pend,
   output logic [3:0]    pend_x,
   output logic [2:0]    pend_y,
   output logic [3:0]    pend_code
);

   pstate_t       state;
   pstate_t       try_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] try_cnt;
   logic          carry_q;
   logic          chop_q;
   logic          carry_rise;
   logic          chop_rise;
   logic          need;
   logic [3:0]    need_code;
   logic          advance;
   logic          commit;

   assign carry_rise = carry & ~carry_q;
   assign chop_rise  = chop & ~chop_q;

   // State, counter, edge-detect and pending-slot registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= P_NOTHING;
         cnt       <= '0;
         carry_q   <= 1'b0;
         chop_q    <= 1'b0;
         pend      <= 1'b0;
         pend_x    <= '0;
         pend_y    <= '0;
         pend_code <= '0;
      end else begin
         if (frame_tick) begin
            carry_q <= carry;
            chop_q  <= chop;
         end
         if (advance) begin
            state <= try_state;
            cnt   <= try_cnt;
         end
         if (commit) begin
            pend      <= 1'b1;
            pend_x    <= front_x;
            pend_y    <= front_y;
            pend_code <= need_code;
         end else if (grant) begin
            pend <= 1'b0;
         end
      end
   end

   // Candidate next state/counter and the grid write it would need.
   always_comb begin
      try_state = state;
      try_cnt   = cnt;
      need      = 1'b0;
      need_code = G_EMPTY;
      if (state == P_NOTHING) begin
         if (carry_rise && is_pickup(obj_front)) begin
            try_state = grid_to_held(obj_front);
            need      = 1'b1;
            need_code = G_EMPTY;
         end else if (chop && obj_front == G_ONION_WHOLE) begin
            try_state = P_CHOPPING;
            try_cnt   = CW'(1);
         end
      end else if (state == P_CHOPPING) begin
         if (chop && obj_front == G_ONION_WHOLE) begin
            if (cnt == CW'(CHOP_FRAMES - 1)) begin
               try_state = P_NOTHING;
               try_cnt   = '0;
               need      = 1'b1;
               need_code = G_ONION_CHOPPED;
            end else begin
               try_cnt = cnt + CW'(1);
            end
         end else begin
            try_state = P_NOTHING;
            try_cnt   = '0;
         end
      end else if (is_holding(state)) begin
         if (carry_rise && obj_front == G_EMPTY) begin
            try_state = P_NOTHING;
            need      = 1'b1;
            need_code = held_to_grid(state);
         end else begin
            case (state)
               P_POT_EMPTY: if (chop_rise && obj_front == G_ONION_CHOPPED) begin
                  try_state = P_POT_RAW;
                  need      = 1'b1;
                  need_code = G_EMPTY;
               end
               P_BOWL_EMPTY: if (chop_rise && obj_front == G_POT_COOKED) begin
                  try_state = P_BOWL_FULL;
                  need      = 1'b1;
                  need_code = G_POT_EMPTY;
               end
               P_POT_COOKED: if (chop_rise && obj_front == G_BOWL_EMPTY) begin
                  try_state = P_POT_EMPTY;
                  need      = 1'b1;
                  need_code = G_BOWL_FULL;
               end
               P_EXT_OFF: if (chop) begin
                  try_state = P_EXT_ON;
               end
               P_EXT_ON: begin
                  if (!chop) begin
                     try_state = P_EXT_OFF;
                  end else if (obj_front == G_FIRE) begin
                     need      = 1'b1;
                     need_code = G_EMPTY;
                  end else if (obj_front == G_POT_FIRE) begin
                     need      = 1'b1;
                     need_code = G_POT_EMPTY;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Request/commit qualification and visible outputs.
   always_comb begin
      req        = frame_tick & ~pend & need;
      commit     = req & ~blocked;
      advance    = frame_tick & ~pend & ~(need & blocked);
      state_code = state;
      progress   = cnt;
   end

endmodule

// File: rtl/multi_player_hold_fsm.sv
// Top: one action slot per player, same-cell conflict resolution and a
// round-robin arbiter onto the single grid write port.
module multi_player_hold_fsm
   import multi_player_hold_fsm_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int CHOP_FRAMES = 60,
   parameter int CW          = $clog2(CHOP_FRAMES + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            frame_tick,
   input  logic [NUM_PLAYERS-1:0]          chop,
   input  logic [NUM_PLAYERS-1:0]          carry,
   input  logic [NUM_PLAYERS-1:0][3:0]     obj_front,
   input  logic [NUM_PLAYERS-1:0][3:0]     front_x,
   input  logic [NUM_PLAYERS-1:0][2:0]     front_y,
   output logic [NUM_PLAYERS-1:0][3:0]     player_state,
   output logic [NUM_PLAYERS-1:0][CW-1:0]  chop_progress,
   multi_player_hold_fsm_if.master         wr
);

   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

   logic [NUM_PLAYERS-1:0]      req;
   logic [NUM_PLAYERS-1:0]      blocked;
   logic [NUM_PLAYERS-1:0]      grant;
   logic [NUM_PLAYERS-1:0]      pend;
   logic [NUM_PLAYERS-1:0][3:0] pend_x;
   logic [NUM_PLAYERS-1:0][2:0] pend_y;
   logic [NUM_PLAYERS-1:0][3:0] pend_code;
   logic [PW-1:0]               ptr;
   logic [PW-1:0]               sel;
   logic                        fire;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_slot
      player_action_slot #(
         .CHOP_FRAMES (CHOP_FRAMES),
         .CW          (CW)
      ) u_slot (
         .clk        (clk),
         .reset      (reset),
         .frame_tick (frame_tick),
         .chop       (chop[g]),
         .carry      (carry[g]),
         .obj_front  (obj_front[g]),
         .front_x    (front_x[g]),
         .front_y    (front_y[g]),
         .blocked    (blocked[g]),
         .grant      (grant[g]),
         .state_code (player_state[g]),
         .progress   (chop_progress[g]),
         .req        (req[g]),
         .pend       (pend[g]),
         .pend_x     (pend_x[g]),
         .pend_y     (pend_y[g]),
         .pend_code  (pend_code[g])
      );
      assign grant[g] = fire && (sel == PW'(g));
   end

   // A write is held off if its cell is already pending or a lower-index
   // player is asking for the same cell this tick.
   always_comb begin
      blocked = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         for (int j = 0; j < NUM_PLAYERS; j++) begin
            if (pend[j] && pend_x[j] == front_x[i] && pend_y[j] == front_y[i]) begin
               blocked[i] = 1'b1;
            end
         end
         for (int j = 0; j < i; j++) begin
            if (req[j] && front_x[j] == front_x[i] && front_y[j] == front_y[i]) begin
               blocked[i] = 1'b1;
            end
         end
      end
   end

   // First pending slot at or after the round-robin pointer.
   always_comb begin
      int   idx;
      logic found;
      sel   = ptr;
      found = 1'b0;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
         idx = (int'(ptr) + k) % NUM_PLAYERS;
         if (!found && pend[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
   end

   assign wr.wr_valid  = |pend;
   assign wr.wr_x      = pend_x[sel];
   assign wr.wr_y      = pend_y[sel];
   assign wr.wr_code   = pend_code[sel];
   assign wr.wr_player = sel;
   assign fire         = wr.wr_valid & wr.wr_ready;

   // Pointer moves just past the player that was served.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (fire) begin
         ptr <= (int'(sel) == NUM_PLAYERS - 1) ? '0 : sel + PW'(1);
      end
   end

endmodule
